mem_stage_ext: RTL

MEM_STAGE_EXT -- requirements
Module: mem_stage_ext

---
 rtl/mips_defs_pkg.sv | 51 +++++
 rtl/mem_lane_unit.sv | 65 ++++++
 rtl/mem_stage_ext.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct constants, memory-op decode and MEM-stage FSM encoding.
package mips_defs_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnJr      = 6'h08;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  typedef enum logic [3:0] {
    MemNone, MemLw, MemLh, MemLhu, MemLb, MemLbu, MemSw, MemSh, MemSb
  } mem_op_e;

  function automatic mem_op_e decode_mem_op(input logic [5:0] opcode);
    case (opcode)
      OpLw:    return MemLw;
      OpLh:    return MemLh;
      OpLhu:   return MemLhu;
      OpLb:    return MemLb;
      OpLbu:   return MemLbu;
      OpSw:    return MemSw;
      OpSh:    return MemSh;
      OpSb:    return MemSb;
      default: return MemNone;
    endcase
  endfunction

  // Register-writing non-load instructions; jr is the only R-type without a destination.
  function automatic logic alu_regwrite(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OpSpecial:                             return funct != FnJr;
      OpAddiu, OpOri, OpLui, OpAddi, OpJal:  return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane store merge, load extension and alignment check for one 32-bit word.
module mem_lane_unit
  import mips_defs_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        is_load,
  output logic        is_store
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    is_load  = (op == MemLw) || (op == MemLh) || (op == MemLhu) ||
               (op == MemLb) || (op == MemLbu);
    is_store = (op == MemSw) || (op == MemSh) || (op == MemSb);
    misaligned = (((op == MemLw) || (op == MemSw)) && (byte_off != 2'b00)) ||
                 (((op == MemLh) || (op == MemLhu) || (op == MemSh)) && byte_off[0]);

    half_sel = byte_off[1] ? old_word[31:16] : old_word[15:0];
    case (byte_off)
      2'd0:    byte_sel = old_word[7:0];
      2'd1:    byte_sel = old_word[15:8];
      2'd2:    byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase

    merged = old_word;
    case (op)
      MemSw: merged = wdata;
      MemSh: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      MemSb: begin
        case (byte_off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = old_word;
    endcase

    load_data = '0;
    if (!misaligned) begin
      case (op)
        MemLw:   load_data = old_word;
        MemLh:   load_data = {{16{half_sel[15]}}, half_sel};
        MemLhu:  load_data = {16'h0000, half_sel};
        MemLb:   load_data = {{24{byte_sel[7]}}, byte_sel};
        MemLbu:  load_data = {24'h000000, byte_sel};
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_ext.sv
// MIPS MEM stage with local data array, configurable wait states and registered results.
module mem_stage_ext
  import mips_defs_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  wreg_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  wreg_out,
  output logic [31:0] alu_out,
  output logic [31:0] load_out,
  output logic        regwrite_out,
  output logic        addr_err,
  output logic        st_en,
  output logic [31:0] st_addr,
  output logic [31:0] st_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [0:0]  state_q;
  logic [2:0]  cnt_q;
  logic [31:0] lat_instr_q, lat_pc_q, lat_alu_q, lat_wdata_q;
  logic [4:0]  lat_wreg_q;
  logic [31:0] mem_q [Depth];

  logic [31:0] cur_instr, cur_pc, cur_alu, cur_wdata;
  logic [4:0]  cur_wreg;
  logic [ADDR_W-1:0] idx;
  mem_op_e     cur_op;
  logic        is_mem, accept_wait, complete, st_commit, reg_wr;
  logic [31:0] rd_word, merged, load_data;
  logic        misaligned, is_load, is_store;

  // While busy, upstream holds its inputs but we work from the latched copy.
  always_comb begin
    cur_instr = (state_q == StBusy) ? lat_instr_q : instr_in;
    cur_pc    = (state_q == StBusy) ? lat_pc_q    : pc_in;
    cur_alu   = (state_q == StBusy) ? lat_alu_q   : alu_in;
    cur_wdata = (state_q == StBusy) ? lat_wdata_q : wdata_in;
    cur_wreg  = (state_q == StBusy) ? lat_wreg_q  : wreg_in;
    cur_op    = decode_mem_op(cur_instr[31:26]);
    is_mem    = cur_op != MemNone;
    idx       = cur_alu[ADDR_W+1:2];
    rd_word   = mem_q[idx];

    accept_wait = (state_q == StIdle) && in_valid && is_mem && (WAIT != 0);
    complete    = ((state_q == StIdle) && in_valid && !(is_mem && (WAIT != 0))) ||
                  ((state_q == StBusy) && (cnt_q == 3'd1));
    st_commit   = complete && is_store && !misaligned;
    reg_wr      = !misaligned && (is_load || alu_regwrite(cur_instr[31:26], cur_instr[5:0]));

    stall   = !reset && (accept_wait || ((state_q == StBusy) && (cnt_q != 3'd1)));
    st_en   = !reset && st_commit;
    st_addr = st_en ? {cur_alu[31:2], 2'b00} : '0;
    st_data = st_en ? merged : '0;
  end

  mem_lane_unit u_lane (
    .op        (cur_op),
    .byte_off  (cur_alu[1:0]),
    .old_word  (rd_word),
    .wdata     (cur_wdata),
    .merged    (merged),
    .load_data (load_data),
    .misaligned(misaligned),
    .is_load   (is_load),
    .is_store  (is_store)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lat_instr_q  <= '0;
      lat_pc_q     <= '0;
      lat_alu_q    <= '0;
      lat_wdata_q  <= '0;
      lat_wreg_q   <= '0;
      out_valid    <= 1'b0;
      instr_out    <= '0;
      pc_out       <= '0;
      wreg_out     <= '0;
      alu_out      <= '0;
      load_out     <= '0;
      regwrite_out <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      out_valid <= complete;
      if (accept_wait) begin
        state_q     <= StBusy;
        cnt_q       <= 3'(WAIT);
        lat_instr_q <= instr_in;
        lat_pc_q    <= pc_in;
        lat_alu_q   <= alu_in;
        lat_wdata_q <= wdata_in;
        lat_wreg_q  <= wreg_in;
      end else if (state_q == StBusy) begin
        if (cnt_q == 3'd1) begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
      if (complete) begin
        instr_out    <= cur_instr;
        pc_out       <= cur_pc;
        alu_out      <= cur_alu;
        wreg_out     <= reg_wr ? cur_wreg : 5'd0;
        load_out     <= load_data;
        regwrite_out <= reg_wr;
        addr_err     <= misaligned;
      end
    end
  end

  // Array cleared while reset is held; written only on a store's completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (st_commit) begin
      mem_q[idx] <= merged;
    end
  end

endmodule
